// File: rtl/seq_detector_prog_if.sv
// Signal bundle for seq_detector_prog: pattern programming, serial sample
// inputs and the detection/counter outputs.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
);
    logic               enable;
    logic               sequence_in;
    logic               load_pattern;
    logic [MAX_LEN-1:0] pattern_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap_en;
    logic               clear_count;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    modport master (
        output enable, sequence_in, load_pattern, pattern_in, len_in,
               overlap_en, clear_count,
        input  detector_out, match_count, count_sat
    );

    modport slave (
        input  enable, sequence_in, load_pattern, pattern_in, len_in,
               overlap_en, clear_count,
        output detector_out, match_count, count_sat
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with Moore-timed pulse output,
// selectable overlap mode and a saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN       = 8,
    parameter int                 LEN_W         = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W         = 8,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 RESET_LEN     = 4
) (
    input  logic               clock,
    input  logic               reset,
    seq_detector_prog_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               detector_out_q, detector_out_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               count_sat_q, count_sat_d;

    logic [MAX_LEN-1:0] nh_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W-1:0]   nf_s;
    logic               match_s;
    logic               hit_s;

    // Candidate sample: shifted history, advanced fill and masked pattern compare.
    always_comb begin
        nh_s = {history_q[MAX_LEN-2:0], bus.sequence_in};
        if (fill_q >= MAX_LEN_V) begin
            nf_s = MAX_LEN_V;
        end else begin
            nf_s = fill_q + LEN_W'(1);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (len_q > LEN_W'(i));
        end
        match_s = (len_q != LEN_W'(0)) && (nf_s >= len_q) &&
                  (((nh_s ^ pattern_q) & mask_s) == {MAX_LEN{1'b0}});
        hit_s   = bus.enable && !bus.load_pattern && match_s;
    end

    // Pattern programming and history/fill update; a load flushes the history.
    always_comb begin
        pattern_d      = pattern_q;
        len_d          = len_q;
        history_d      = history_q;
        fill_d         = fill_q;
        detector_out_d = 1'b0;
        if (bus.load_pattern) begin
            pattern_d = bus.pattern_in;
            len_d     = (bus.len_in > MAX_LEN_V) ? MAX_LEN_V : bus.len_in;
            history_d = {MAX_LEN{1'b0}};
            fill_d    = LEN_W'(0);
        end else if (bus.enable) begin
            history_d      = nh_s;
            detector_out_d = match_s;
            // Non-overlapping mode demands len fresh bits after each hit.
            if (match_s && !bus.overlap_en) begin
                fill_d = LEN_W'(0);
            end else begin
                fill_d = nf_s;
            end
        end else begin
            detector_out_d = 1'b0;
        end
    end

    // Saturating hit counter; clear beats a coincident hit.
    always_comb begin
        if (bus.clear_count) begin
            match_count_d = {CNT_W{1'b0}};
        end else if (hit_s && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end else begin
            match_count_d = match_count_q;
        end
        count_sat_d = (match_count_d == CNT_MAX);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q      <= RESET_PATTERN;
            len_q          <= LEN_W'(RESET_LEN);
            history_q      <= {MAX_LEN{1'b0}};
            fill_q         <= LEN_W'(0);
            detector_out_q <= 1'b0;
            match_count_q  <= {CNT_W{1'b0}};
            count_sat_q    <= 1'b0;
        end else begin
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            history_q      <= history_d;
            fill_q         <= fill_d;
            detector_out_q <= detector_out_d;
            match_count_q  <= match_count_d;
            count_sat_q    <= count_sat_d;
        end
    end

    assign bus.detector_out = detector_out_q;
    assign bus.match_count  = match_count_q;
    assign bus.count_sat    = count_sat_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed vector table, corner
// sequences and random stimulus against a bit-queue reference model.
module tb_seq_detector_prog;
    logic clock;
    logic reset;

    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(4)) bus4 ();

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));
    seq_detector_prog #(.MAX_LEN(8), .CNT_W(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits sampled since last flush, plus programmed pattern.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_bits[$];
    bit         m_out;
    int         m_cnt8;
    int         m_cnt4;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       en;
        logic       seq;
        logic       ovl;
        logic       clr;
        logic       eo;
        int         ec;
    } vec_t;
    vec_t tbl[$];

    function automatic void row(input logic rst, input logic ld, input logic [7:0] pat,
                                input logic [3:0] len, input logic en, input logic seq,
                                input logic ovl, input logic clr, input logic eo, input int ec);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pat = pat; v.len = len; v.en = en;
        v.seq = seq; v.ovl = ovl; v.clr = clr; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_match();
        int n;
        n = m_bits.size();
        if (m_len == 0 || n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_bits[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pat = 8'h0B; m_len = 4; m_bits.delete(); m_out = 1'b0; m_cnt8 = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] p, input logic [3:0] l,
                              input logic e, input logic s, input logic o, input logic c);
        bit hit;
        hit = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = (int'(l) > 8) ? 8 : int'(l);
            m_bits.delete();
            m_out = 1'b0;
        end else if (e) begin
            m_bits.push_back(s);
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            hit   = model_match();
            m_out = hit;
            if (hit && !o) m_bits.delete();
        end else begin
            m_out = 1'b0;
        end
        if (c) begin
            m_cnt8 = 0; m_cnt4 = 0;
        end else if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    task automatic set_in(input logic ld, input logic [7:0] p, input logic [3:0] l,
                          input logic e, input logic s, input logic o, input logic c);
        bus8.load_pattern = ld; bus8.pattern_in = p; bus8.len_in = l; bus8.enable = e;
        bus8.sequence_in = s;   bus8.overlap_en = o; bus8.clear_count = c;
        bus4.load_pattern = ld; bus4.pattern_in = p; bus4.len_in = l; bus4.enable = e;
        bus4.sequence_in = s;   bus4.overlap_en = o; bus4.clear_count = c;
    endtask

    task automatic compare_model();
        check("out8", int'(bus8.detector_out), int'(m_out));
        check("cnt8", int'(bus8.match_count), m_cnt8);
        check("sat8", int'(bus8.count_sat), int'(m_cnt8 == 255));
        check("out4", int'(bus4.detector_out), int'(m_out));
        check("cnt4", int'(bus4.match_count), m_cnt4);
        check("sat4", int'(bus4.count_sat), int'(m_cnt4 == 15));
    endtask

    task automatic drive(input logic ld, input logic [7:0] p, input logic [3:0] l,
                         input logic e, input logic s, input logic o, input logic c);
        set_in(ld, p, l, e, s, o, c);
        @(posedge clock);
        model_step(ld, p, l, e, s, o, c);
        #1;
        compare_model();
    endtask

    task automatic bit_in(input logic s, input logic o);
        drive(1'b0, 8'h00, 4'd0, 1'b1, s, o, 1'b0);
    endtask

    task automatic do_reset();
        set_in(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_async_out", int'(bus8.detector_out), 0);
        check("rst_async_cnt", int'(bus8.match_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        compare_model();
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        set_in(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        model_reset();

        // rst ld pat len en seq ovl clr | exp_out exp_cnt
        row(1,0,8'h00,4'd0, 0,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0); row(0,0,8'h00,4'd0, 1,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0); row(0,0,8'h00,4'd0, 1,1,1,0, 1,1);
        row(0,0,8'h00,4'd0, 1,0,1,0, 0,1); row(0,0,8'h00,4'd0, 1,1,1,0, 0,1);
        row(0,0,8'h00,4'd0, 1,1,1,0, 1,2);
        row(1,0,8'h00,4'd0, 0,0,0,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,0,0, 0,0); row(0,0,8'h00,4'd0, 1,0,0,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,0,0, 0,0); row(0,0,8'h00,4'd0, 1,1,0,0, 1,1);
        row(0,0,8'h00,4'd0, 1,0,0,0, 0,1); row(0,0,8'h00,4'd0, 1,1,0,0, 0,1);
        row(0,0,8'h00,4'd0, 1,1,0,0, 0,1);
        row(1,0,8'h00,4'd0, 0,0,1,0, 0,0);
        row(0,1,8'h01,4'd1, 0,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 1,1); row(0,0,8'h00,4'd0, 1,1,1,0, 1,2);
        row(0,0,8'h00,4'd0, 1,1,1,0, 1,3); row(0,0,8'h00,4'd0, 0,1,1,0, 0,3);
        row(0,0,8'h00,4'd0, 0,1,1,0, 0,3); row(0,0,8'h00,4'd0, 1,0,1,0, 0,3);
        row(0,0,8'h00,4'd0, 1,1,1,0, 1,4);
        row(1,0,8'h00,4'd0, 0,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0); row(0,0,8'h00,4'd0, 1,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0);
        row(1,0,8'h00,4'd0, 0,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0); row(0,0,8'h00,4'd0, 1,0,1,0, 0,0);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,0); row(0,0,8'h00,4'd0, 1,1,1,0, 1,1);
        row(0,1,8'hA5,4'd12,0,0,1,0, 0,1);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,1); row(0,0,8'h00,4'd0, 1,0,1,0, 0,1);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,1); row(0,0,8'h00,4'd0, 1,0,1,0, 0,1);
        row(0,0,8'h00,4'd0, 1,0,1,0, 0,1); row(0,0,8'h00,4'd0, 1,1,1,0, 0,1);
        row(0,0,8'h00,4'd0, 1,0,1,0, 0,1); row(0,0,8'h00,4'd0, 1,1,1,0, 1,2);
        row(0,1,8'h01,4'd0, 0,0,1,0, 0,2);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,2); row(0,0,8'h00,4'd0, 1,1,1,0, 0,2);
        row(0,0,8'h00,4'd0, 1,1,1,0, 0,2); row(0,0,8'h00,4'd0, 1,1,1,0, 0,2);
        row(0,1,8'h01,4'd1, 0,0,1,0, 0,2);
        row(0,0,8'h00,4'd0, 1,1,1,1, 1,0); row(0,0,8'h00,4'd0, 1,1,1,0, 1,1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            else drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].en, tbl[i].seq, tbl[i].ovl, tbl[i].clr);
            check($sformatf("tbl%0d_out", i), int'(bus8.detector_out), int'(tbl[i].eo));
            check($sformatf("tbl%0d_cnt", i), int'(bus8.match_count), tbl[i].ec);
        end

        // 8-bit pattern after random prefix: exactly one pulse on the final 0.
        do_reset();
        drive(1'b1, 8'hF0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            bit_in(1'($urandom_range(0, 1)), 1'b0);
            pulses += int'(bus8.detector_out);
        end
        for (int k = 7; k >= 0; k--) begin
            bit_in(((k >= 4) ? 1'b1 : 1'b0), 1'b0);
            pulses += int'(bus8.detector_out);
        end
        check("f0_final", int'(bus8.detector_out), 1);
        check("f0_pulses", pulses, 1);

        // Load mid-stream discards the partial pattern already shifted in.
        for (int k = 0; k < 6; k++) bit_in(((k < 4) ? 1'b1 : 1'b0), 1'b0);
        drive(1'b1, 8'hF0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 2; k++) begin
            bit_in(1'b0, 1'b0);
            pulses += int'(bus8.detector_out);
        end
        check("midload_nohit", pulses, 0);
        for (int k = 7; k >= 0; k--) bit_in(((k >= 4) ? 1'b1 : 1'b0), 1'b0);
        check("midload_hit", int'(bus8.detector_out), 1);

        // Counter saturation on the 4-bit instance, then clear against a hit.
        do_reset();
        drive(1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) bit_in(1'b1, 1'b1);
        check("sat_cnt4", int'(bus4.match_count), 15);
        check("sat_flag4", int'(bus4.count_sat), 1);
        check("sat_cnt8", int'(bus8.match_count), 20);
        drive(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_out", int'(bus4.detector_out), 1);
        check("clr_cnt4", int'(bus4.match_count), 0);
        check("clr_sat4", int'(bus4.count_sat), 0);

        // Zero length never detects.
        drive(1'b1, 8'($urandom), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            bit_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            pulses += int'(bus8.detector_out);
        end
        check("len0_pulses", pulses, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 31) == 0),
                      8'($urandom),
                      ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3)),
                      1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 63) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
